// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate extender: mode codes and the
// occupancy states of the two-entry output buffer.
package imm_ext_pkg;

  localparam logic [1:0] MODE_SEXT   = 2'd0;
  localparam logic [1:0] MODE_ZEXT   = 2'd1;
  localparam logic [1:0] MODE_UPPER  = 2'd2;
  localparam logic [1:0] MODE_BRANCH = 2'd3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL1 = 2'd1,
    ST_FULL2 = 2'd2
  } occ_state_t;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extension: sign, zero, upper placement, and
// sign-extend-then-shift for branch offsets.
module imm_extend_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic [OUT_W-1:0] ext_data
);

  logic signed [IN_W-1:0] in_signed;
  logic [OUT_W-1:0]       sext;
  logic [OUT_W-1:0]       zext;

  assign in_signed = in_data;
  // Size casts avoid zero-width replications when OUT_W equals IN_W.
  assign sext      = OUT_W'(in_signed);
  assign zext      = OUT_W'(in_data);

  always_comb begin
    ext_data = sext;
    case (in_mode)
      MODE_SEXT:   ext_data = sext;
      MODE_ZEXT:   ext_data = zext;
      MODE_UPPER:  ext_data = zext << (OUT_W - IN_W);
      MODE_BRANCH: ext_data = sext << BR_SHIFT;
      default:     ext_data = sext;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with a main output register and a skid
// register so that in_ready can be a flop yet no item is ever dropped.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 32,
  parameter int BR_SHIFT = 2,
  parameter int TAG_W    = 5,
  parameter int CNT_W    = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_neg,
  output logic [CNT_W-1:0] acc_cnt
);

  if (OUT_W < IN_W + BR_SHIFT || OUT_W < IN_W) begin : g_bad_widths
    $error("imm_extend_pipe: OUT_W must be >= IN_W + BR_SHIFT");
  end

  // Handshake: an item moves on a rising edge when valid && ready on that
  // side; out_valid and the payload hold while out_valid && !out_ready.
  // in_ready is registered and means "skid register is empty".

  occ_state_t       state;
  logic [OUT_W-1:0] ext_data;
  logic [OUT_W-1:0] m_data;
  logic [TAG_W-1:0] m_tag;
  logic [OUT_W-1:0] s_data;
  logic [TAG_W-1:0] s_tag;
  logic             accept;
  logic             drain;

  imm_extend_core #(
    .IN_W     (IN_W),
    .OUT_W    (OUT_W),
    .BR_SHIFT (BR_SHIFT)
  ) u_core (
    .in_data  (in_data),
    .in_mode  (in_mode),
    .ext_data (ext_data)
  );

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      m_data    <= '0;
      m_tag     <= '0;
      s_data    <= '0;
      s_tag     <= '0;
      acc_cnt   <= '0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            m_data    <= ext_data;
            m_tag     <= in_tag;
            out_valid <= 1'b1;
            state     <= ST_FULL1;
          end
        end
        ST_FULL1: begin
          if (accept && drain) begin
            m_data <= ext_data;
            m_tag  <= in_tag;
          end else if (accept) begin
            s_data   <= ext_data;
            s_tag    <= in_tag;
            in_ready <= 1'b0;
            state    <= ST_FULL2;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= ST_EMPTY;
          end
        end
        ST_FULL2: begin
          // in_ready is low here, so only the older skid item can move up.
          if (drain) begin
            m_data   <= s_data;
            m_tag    <= s_tag;
            in_ready <= 1'b1;
            state    <= ST_FULL1;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_data = m_data;
  assign out_tag  = m_tag;
  assign out_neg  = m_data[OUT_W-1];

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
- Parametrised, pipelined immediate extender for the datapath decode stage.
- Supports four modes: sign-extend, zero-extend, upper-load placement, and sign-extend with left shift for branch offsets.
- Uses a valid/ready handshake and a 2-entry skid buffer, so decode back-pressure never drops an immediate.
- Sits between instruction decode and the ALU-source mux. A per-item tag travels with the data, and an accepted-item counter is provided for debug.

Parameters:
- IN_W, 16, width of the immediate field.
- OUT_W, 32, width of the extended result. Requires OUT_W >= IN_W + BR_SHIFT and OUT_W >= IN_W; elaboration error otherwise.
- BR_SHIFT, 2, left-shift amount applied in MODE_BRANCH.
- TAG_W, 5, width of the sideband tag (e.g. destination register).
- CNT_W, 16, width of the accepted-item counter.

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  synchronous, active-low reset
- flush  input  1  synchronous pipeline flush (branch mispredict)
- in_valid  input  1  input item present
- in_ready  output  1  block can accept an item this cycle
- in_data  input  IN_W  raw immediate
- in_mode  input  2  extension mode: 0=SEXT, 1=ZEXT, 2=UPPER, 3=BRANCH
- in_tag  input  TAG_W  sideband tag
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result this cycle
- out_data  output  OUT_W  extended result
- out_tag  output  TAG_W  tag that travelled with the item
- out_neg  output  1  MSB of out_data
- acc_cnt  output  CNT_W  number of items accepted since reset

Behaviour:
- Extension rules, computed on the input side:
  - SEXT: {(OUT_W-IN_W){in_data[IN_W-1]}, in_data}.
  - ZEXT: {(OUT_W-IN_W){0}, in_data}.
  - UPPER: {in_data, (OUT_W-IN_W){0}}.
  - BRANCH: SEXT result shifted left by BR_SHIFT, zeros filled in at the LSBs; bits shifted out of the top are discarded.
- Handshake:
  - An item transfers in when in_valid && in_ready at a rising edge.
  - An item transfers out when out_valid && out_ready.
  - Payload and out_valid stay stable while out_valid && !out_ready.
- Storage is two entries: a main output register (M) and a skid register (S).
- in_ready is a register: 1 when S is empty. It does not combinationally depend on out_ready.
- Latency: 1 cycle from accept to out_valid when M is empty or draining. Full throughput of 1 item per cycle with out_ready held high.
- States (occupancy):
  - EMPTY, FULL1 (M valid), FULL2 (M and S valid).
  - EMPTY --accept--> FULL1.
  - FULL1 --accept & !drain--> FULL2.
  - FULL1 --drain & !accept--> EMPTY.
  - FULL1 --accept & drain--> FULL1 (M loads the new item).
  - FULL2 --drain--> FULL1 (M loads S, S is cleared). No accept is possible in FULL2 because in_ready=0.
- Ordering: strict FIFO; S is always older than any newly accepted item.
- acc_cnt increments by 1 on every accept and wraps modulo 2^CNT_W (0xFFFF + 1 -> 0x0000). It is not affected by flush.
- flush:
  - Next cycle: state EMPTY, out_valid=0, in_ready=1.
  - An item presented in the flush cycle is dropped and not counted.
- Reset (Reset=0 at an edge): out_valid=0, in_ready=1, out_data=0, out_tag=0, out_neg=0, acc_cnt=0, state EMPTY.
- Reset mid-operation discards all stored items. Reset has priority over flush, and flush has priority over accept and drain.
- out_data, out_tag and out_neg are don't-care when out_valid=0, but are held at their last value; they are not required to clear except on reset.

Decomposition:
- Shared package imm_ext_pkg:
  - Mode constants MODE_SEXT=2'd0, MODE_ZEXT=2'd1, MODE_UPPER=2'd2, MODE_BRANCH=2'd3.
  - Occupancy state encoding ST_EMPTY, ST_FULL1, ST_FULL2.
- One combinational sub-module, imm_extend_core (in_data, in_mode -> ext_data), parametrised by IN_W, OUT_W and BR_SHIFT.
- The top level holds the skid buffer, the FSM and the counter.

Test Plan:
- Modes with out_ready=1, in_data=16'h8004:
  - SEXT -> 32'hFFFF8004.
  - ZEXT -> 32'h00008004.
  - UPPER -> 32'h80040000.
  - BRANCH -> 32'hFFFE0010.
  - Each arrives 1 cycle after accept, with out_neg=1,0,1,1.
- Back-pressure: stream tags 1..6 with out_ready low for 3 cycles -> in_ready drops after 2 accepts, no item is lost or duplicated, output tag order is 1..6, and payload is stable while stalled.
- Throughput: 100 back-to-back items with out_ready=1 -> 100 outputs in 101 cycles, acc_cnt=100.
- Flush: with FULL2 and in_valid=1, assert flush -> next cycle out_valid=0, in_ready=1, acc_cnt unchanged, and the flushed-cycle item never appears.
- Reset mid-stream: hold Reset=0 for one edge while in FULL1 -> all outputs 0, acc_cnt=0. The first accept after release is output correctly.
- Counter wrap: preload by 65535 accepts, then 1 more -> acc_cnt=0x0000.
